pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Sequences a fabric PLL (50 MHz refclk) from power-up to stable operation, and holds reset on the downstream clock domain until lock is qualified.
- Drives the PLL reset and monitors its asynchronous locked output.
- Retries on lock timeout; enters a fault state after a bounded number of failed retries.
- Re-sequences the PLL automatically on lock loss or on software request.

Parameters:
- RST_PULSE_CYCLES, 50: PLL reset pulse length in refclk cycles (1 us at 50 MHz).
- LOCK_TIMEOUT_CYCLES, 50000: maximum wait for lock after reset release (1 ms).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles needed to qualify lock.
- MAX_RETRIES, 4: failed lock attempts before FAULT, range 1..15.
- CNT_W, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- refclk, input, 1: free-running reference clock; the only clock.
- rst, input, 1: asynchronous reset, active-high.
- pll_locked_in, input, 1: PLL locked; asynchronous to refclk.
- recal_req, input, 1: single-cycle pulse requesting PLL re-sequencing.
- fault_clr, input, 1: single-cycle pulse that leaves FAULT.
- pll_rst, output, 1: reset to the PLL, active-high.
- sys_rst_out, output, 1: reset for downstream logic, active-high.
- lock_stable, output, 1: high only in LOCKED.
- fault, output, 1: high only in FAULT.
- retry_cnt, output, 4: failed attempts in the current sequence.
- lock_lost_count, output, 8: saturating count of lock losses seen in LOCKED.

Behaviour:
- Reset (rst=1, async): state=RESET_PLL, counter=0, retry_cnt=0, lock_lost_count=0, sync flops=0, pll_rst=1, sys_rst_out=1, lock_stable=0, fault=0.
- pll_locked_in passes through a 2-flop synchronizer; locked_s is the second flop.
- All outputs are registered Moore decodes of state. An output changes in the cycle the new state is registered.
- RESET_PLL: pll_rst=1, sys_rst_out=1. Counter runs 0..RST_PULSE_CYCLES-1, then clears and moves to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, sys_rst_out=1.
  - If locked_s=1: go to QUALIFY, counter=0.
  - Else if counter==LOCK_TIMEOUT_CYCLES-1: retry_cnt+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
  - Otherwise counter+1.
- QUALIFY: pll_rst=0, sys_rst_out=1.
  - If locked_s=0: go to WAIT_LOCK with counter=0. retry_cnt is unchanged; glitchy lock is not a retry.
  - If locked_s=1 and counter==LOCK_STABLE_CYCLES-1: go to LOCKED and clear retry_cnt.
  - Otherwise counter+1.
- LOCKED: pll_rst=0, sys_rst_out=0, lock_stable=1.
  - If locked_s=0: lock_lost_count+1, saturating at 255, then go to RESET_PLL with counter=0.
- FAULT: pll_rst=1 (PLL held in reset), sys_rst_out=1, fault=1.
  - Stays in FAULT until fault_clr=1, then goes to RESET_PLL with retry_cnt=0 and counter=0.
- recal_req=1 in WAIT_LOCK, QUALIFY or LOCKED:
  - Goes to RESET_PLL with counter=0 and retry_cnt=0.
  - Takes priority over every other transition in that cycle.
  - Does not increment lock_lost_count, even if lock drops in the same cycle.
- recal_req is ignored in RESET_PLL and FAULT. fault_clr is ignored outside FAULT.
- Counter never wraps; every transition clears it.
- Lock path latency: a pll_locked_in rise registers QUALIFY at cycle +3. sys_rst_out falls LOCK_STABLE_CYCLES cycles after that.
- Lock-loss latency: a pll_locked_in fall in LOCKED raises sys_rst_out 3 cycles later.
- rst asserted mid-sequence forces the reset values immediately and restarts from RESET_PLL.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, clean lock: release rst; raise pll_locked_in 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_out falls 11 cycles after the locked rise; lock_stable=1; retry_cnt=0.
- Lock chatter: locked high 5 cycles, low 3, then high -> QUALIFY aborts to WAIT_LOCK; retry_cnt stays 0; sys_rst_out falls 11 cycles after the final rise.
- Timeout to fault: hold pll_locked_in=0 -> two 4-cycle pll_rst pulses separated by 20-cycle waits; after the second timeout fault=1, pll_rst=1, retry_cnt=2. Pulse fault_clr -> retry_cnt=0, fresh 4-cycle reset pulse.
- Lock loss in LOCKED: drop pll_locked_in -> sys_rst_out=1 and pll_rst=1 3 cycles later; lock_lost_count 0->1. Repeat 300 times -> count saturates at 255.
- recal_req in LOCKED on the same cycle locked_s falls -> RESET_PLL; lock_lost_count unchanged; retry_cnt=0.
- Async rst asserted mid-QUALIFY -> all outputs return to reset values within the same cycle with no clock edge needed; the sequence restarts cleanly after rst releases.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock-qualification sequencer on refclk.
// Holds downstream reset until PLL lock has been stable long enough.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_in,
    input  logic       recal_req,
    input  logic       fault_clr,
    output logic       pll_rst,
    output logic       sys_rst_out,
    output logic       lock_stable,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_count
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_QUALIFY,
        S_LOCKED,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       retry_inc;
    logic [7:0]       lost_q, lost_d;
    logic             sync1_q, locked_s;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             stable_q, stable_d;
    logic             fault_q, fault_d;

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= pll_locked_in;
            locked_s <= sync1_q;
        end
    end

    // Next-state, shared counter, retry and lock-loss bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        lost_d    = lost_q;
        retry_inc = retry_q + 4'd1;
        unique case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (recal_req) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (locked_s) begin
                    state_d = S_QUALIFY;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT
                                                         : S_RESET_PLL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_QUALIFY: begin
                if (recal_req) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (!locked_s) begin
                    // A lock glitch restarts the wait but is not a retry.
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOCKED: begin
                if (recal_req) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (!locked_s) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs move with the state.
    always_comb begin
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_LOCKED);
        stable_d  = (state_d == S_LOCKED);
        fault_d   = (state_d == S_FAULT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            stable_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            stable_q  <= stable_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst_out     = sys_rst_q;
    assign lock_stable     = stable_q;
    assign fault           = fault_q;
    assign retry_cnt       = retry_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with small cycle parameters.
// Expected values are queued with the stimulus and popped on observation.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked_in;
    logic       recal_req;
    logic       fault_clr;
    logic       pll_rst;
    logic       sys_rst_out;
    logic       lock_stable;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_llc = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked_in  (pll_locked_in),
        .recal_req      (recal_req),
        .fault_clr      (fault_clr),
        .pll_rst        (pll_rst),
        .sys_rst_out    (sys_rst_out),
        .lock_stable    (lock_stable),
        .fault          (fault),
        .retry_cnt      (retry_cnt),
        .lock_lost_count(lock_lost_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.exp = 32'(v);
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk(e.tag, got, e.exp);
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst_out;
            2:       return lock_stable;
            default: return fault;
        endcase
    endfunction

    // Number of consecutive samples (current one included) with sig==val.
    task automatic count_while(input int sel, input logic val, output int n);
        n = 0;
        while (sig(sel) === val && n < 400) begin
            n++;
            tick();
        end
    endtask

    task automatic observe_all_outputs();
        observe(32'(pll_rst));
        observe(32'(sys_rst_out));
        observe(32'(lock_stable));
        observe(32'(fault));
        observe(32'(retry_cnt));
        observe(32'(lock_lost_count));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b1;
        pll_locked_in = 1'b0;
        recal_req     = 1'b0;
        fault_clr     = 1'b0;
        repeat (3) tick();

        // Reset state.
        expect_val("rst_pll_rst", 1);
        expect_val("rst_sys_rst", 1);
        expect_val("rst_lock_stable", 0);
        expect_val("rst_fault", 0);
        expect_val("rst_retry", 0);
        expect_val("rst_llc", 0);
        observe_all_outputs();

        // Power-up and clean lock.
        rst = 1'b0;
        expect_val("pwr_pll_rst_width", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));
        repeat (10) tick();
        pll_locked_in = 1'b1;
        expect_val("pwr_lock_latency", 11);
        count_while(1, 1'b1, n);
        observe(32'(n));
        expect_val("pwr_lock_stable", 1);
        observe(32'(lock_stable));
        expect_val("pwr_retry", 0);
        observe(32'(retry_cnt));

        // First lock loss.
        pll_locked_in = 1'b0;
        expect_val("loss_latency", 3);
        count_while(1, 1'b0, n);
        observe(32'(n));
        expect_val("loss_pll_rst", 1);
        observe(32'(pll_rst));
        exp_llc = 1;
        expect_val("loss_llc", exp_llc);
        observe(32'(lock_lost_count));
        expect_val("loss_pulse_width", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));

        // Lock chatter during qualification.
        pll_locked_in = 1'b1;
        repeat (5) tick();
        pll_locked_in = 1'b0;
        repeat (3) tick();
        pll_locked_in = 1'b1;
        expect_val("chat_lock_latency", 11);
        count_while(1, 1'b1, n);
        observe(32'(n));
        expect_val("chat_retry", 0);
        observe(32'(retry_cnt));
        expect_val("chat_lock_stable", 1);
        observe(32'(lock_stable));

        // recal_req on the cycle the synchronized lock falls.
        pll_locked_in = 1'b0;
        tick();
        tick();
        recal_req = 1'b1;
        tick();
        recal_req = 1'b0;
        expect_val("recal_pll_rst", 1);
        observe(32'(pll_rst));
        expect_val("recal_sys_rst", 1);
        observe(32'(sys_rst_out));
        expect_val("recal_llc", exp_llc);
        observe(32'(lock_lost_count));
        expect_val("recal_retry", 0);
        observe(32'(retry_cnt));

        // Timeouts into FAULT with lock held low.
        expect_val("to_pulse1", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));
        expect_val("to_wait1", 20);
        count_while(0, 1'b0, n);
        observe(32'(n));
        expect_val("to_retry1", 1);
        observe(32'(retry_cnt));
        expect_val("to_fault_early", 0);
        observe(32'(fault));
        expect_val("to_pulse2", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));
        expect_val("to_wait2", 20);
        count_while(0, 1'b0, n);
        observe(32'(n));
        expect_val("flt_fault", 1);
        observe(32'(fault));
        expect_val("flt_pll_rst", 1);
        observe(32'(pll_rst));
        expect_val("flt_retry", 2);
        observe(32'(retry_cnt));
        recal_req = 1'b1;
        tick();
        recal_req = 1'b0;
        repeat (3) tick();
        expect_val("flt_hold", 1);
        observe(32'(fault));
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        expect_val("clr_fault", 0);
        observe(32'(fault));
        expect_val("clr_retry", 0);
        observe(32'(retry_cnt));
        expect_val("clr_pulse", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));

        // Repeated lock losses saturate the counter.
        pll_locked_in = 1'b1;
        count_while(2, 1'b0, n);
        expect_val("sat_first_lock", 1);
        observe(32'(lock_stable));
        for (int i = 0; i < 300; i++) begin
            pll_locked_in = 1'b0;
            count_while(1, 1'b0, n);
            expect_val("sat_loss_latency", 3);
            observe(32'(n));
            if (exp_llc < 255) exp_llc++;
            expect_val("sat_llc", exp_llc);
            observe(32'(lock_lost_count));
            pll_locked_in = 1'b1;
            count_while(2, 1'b0, n);
            expect_val("sat_relock", 1);
            observe(32'(lock_stable));
        end
        expect_val("sat_final_llc", 255);
        observe(32'(lock_lost_count));

        // Async reset in the middle of QUALIFY.
        recal_req = 1'b1;
        tick();
        recal_req = 1'b0;
        count_while(0, 1'b1, n);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        expect_val("arst_pll_rst", 1);
        expect_val("arst_sys_rst", 1);
        expect_val("arst_lock_stable", 0);
        expect_val("arst_fault", 0);
        expect_val("arst_retry", 0);
        expect_val("arst_llc", 0);
        observe_all_outputs();
        tick();
        tick();
        rst = 1'b0;
        expect_val("arst_pulse", 4);
        count_while(0, 1'b1, n);
        observe(32'(n));
        expect_val("arst_relock", 9);
        count_while(1, 1'b1, n);
        observe(32'(n));
        expect_val("arst_lock_stable_up", 1);
        observe(32'(lock_stable));

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
